dll_tx_fc_dllp_scheduler: RTL

Multi-channel flow-control DLLP scheduler for the DLL transmit path. Accepts UpdateFC requests from up to three credit channels (Posted, Non-Posted, Completion), coalesces them per channel, arbitrates round-robin, and emits 48-bit UpdateFC DLLPs through a valid/ready handshake. A refresh timer periodically re-issues the last advertised credits of every channel while the link is DL_Active. It sits between the receive-side credit tracker and the TX DLLP/TLP mux.

---
 rtl/dll_tx_fc_dllp_scheduler.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dll_tx_fc_dllp_scheduler.sv
// dll_tx_fc_dllp_scheduler
//
// Flow-control DLLP scheduler for the DLL transmit path. Collects UpdateFC
// requests from up to three credit channels (P, NP, Cpl), coalesces repeated
// requests per channel, picks one pending channel per cycle round-robin and
// presents a 48-bit UpdateFC DLLP on a valid/ready output. A refresh timer
// re-advertises the last credits of every channel that has already sent
// once, for as long as the link stays DL_Active.
//
// Ports:
//   clk               clock
//   rst               asynchronous active-high reset
//   dlc_state_i[1:0]  DLCMSM state, 2'b11 = DL_Active
//   update_req_i      per-channel update request pulse
//   hdr_credit_i      per-channel header credit, channel i at [8i+7:8i]
//   data_credit_i     per-channel data credit, channel i at [12i+11:12i]
//   dll_dllp_o[47:0]  DLLP, byte 0 in [7:0], CRC in [47:32]
//   dll_dllp_valid_o  DLLP valid
//   dll_dllp_ready_i  downstream accepts the DLLP
//
// Build option:
//   DLL_DLLP_CRC_EN   defined: [47:32] carries the DLLP CRC-16.
//                     undefined: [47:32] is the constant 16'hBEEF.

module dll_tx_fc_dllp_scheduler #(
  parameter int         NUM_CH         = 3,
  parameter logic [2:0] VC_ID          = 3'd0,
  parameter int         REFRESH_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           dlc_state_i,
  input  logic [NUM_CH-1:0]    update_req_i,
  input  logic [NUM_CH*8-1:0]  hdr_credit_i,
  input  logic [NUM_CH*12-1:0] data_credit_i,
  output logic [47:0]          dll_dllp_o,
  output logic                 dll_dllp_valid_o,
  input  logic                 dll_dllp_ready_i
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(REFRESH_CYCLES);
  localparam logic [TW-1:0] TIMER_INIT = TW'(REFRESH_CYCLES - 1);

  // Bytes 0..3 of an UpdateFC DLLP.
  function automatic logic [31:0] dllp_body(input logic [3:0]  dtype,
                                            input logic [7:0]  hdr,
                                            input logic [11:0] data);
    return {data[7:0], hdr[1:0], 2'b00, data[11:8], 2'b00, hdr[7:2],
            dtype, 1'b0, VC_ID};
  endfunction

`ifdef DLL_DLLP_CRC_EN
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      r[k] = v[7-k];
    end
    return r;
  endfunction

  // CRC-16 (poly 100B, seed FFFF), bit 0 of byte 0 enters first; the
  // complemented remainder goes out bit-reversed per byte, high byte first.
  function automatic logic [15:0] dllp_crc(input logic [31:0] body);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < 32; k++) begin
      fb = c[15] ^ body[k];
      c  = {c[14:0], 1'b0};
      if (fb) begin
        c = c ^ 16'h100B;
      end else begin
        c = c;
      end
    end
    c = ~c;
    return {rev8(c[7:0]), rev8(c[15:8])};
  endfunction
`endif

  logic                    active_s;
  logic                    refresh_s;
  logic                    grant_valid_s;
  logic [PW-1:0]           grant_idx_s;
  logic [PW-1:0]           next_ptr_s;
  logic                    load_s;
  logic [31:0]             body_s;
  logic [15:0]             crc_field_s;
  logic [3:0]              type_s;
  logic                    hi_found_s;
  logic                    lo_found_s;
  logic [PW-1:0]           hi_idx_s;
  logic [PW-1:0]           lo_idx_s;

  logic [NUM_CH-1:0]       pending_r;
  logic [NUM_CH-1:0]       seeded_r;
  logic [NUM_CH-1:0][7:0]  pend_hdr_r;
  logic [NUM_CH-1:0][11:0] pend_data_r;
  logic [NUM_CH-1:0][7:0]  last_hdr_r;
  logic [NUM_CH-1:0][11:0] last_data_r;
  logic [PW-1:0]           rr_ptr_r;
  logic [TW-1:0]           timer_r;
  logic [47:0]             dllp_r;
  logic                    valid_r;

  assign active_s  = (dlc_state_i == 2'b11);
  assign refresh_s = active_s && (timer_r == {TW{1'b0}});

  // Round-robin pick: lowest pending index at or above the pointer, else the
  // lowest pending index overall (wrap-around).
  always_comb begin
    hi_found_s = 1'b0;
    hi_idx_s   = {PW{1'b0}};
    lo_found_s = 1'b0;
    lo_idx_s   = {PW{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_r[i]) begin
        lo_found_s = 1'b1;
        lo_idx_s   = PW'(i);
      end else begin
        lo_found_s = lo_found_s;
      end
      if (pending_r[i] && (PW'(i) >= rr_ptr_r)) begin
        hi_found_s = 1'b1;
        hi_idx_s   = PW'(i);
      end else begin
        hi_found_s = hi_found_s;
      end
    end
    grant_valid_s = lo_found_s;
    if (hi_found_s) begin
      grant_idx_s = hi_idx_s;
    end else begin
      grant_idx_s = lo_idx_s;
    end
  end

  // Pointer successor of the granted channel, wrapping at NUM_CH.
  always_comb begin
    if (grant_idx_s == PW'(NUM_CH - 1)) begin
      next_ptr_s = {PW{1'b0}};
    end else begin
      next_ptr_s = grant_idx_s + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // The output register is free when empty or being drained this cycle.
  assign load_s = active_s && grant_valid_s && (!valid_r || dll_dllp_ready_i);

  // DLLP image of the granted channel, CRC computed in the same cycle.
  always_comb begin
    type_s = 4'b1000 + 4'(grant_idx_s);
    body_s = dllp_body(type_s, pend_hdr_r[grant_idx_s], pend_data_r[grant_idx_s]);
`ifdef DLL_DLLP_CRC_EN
    crc_field_s = dllp_crc(body_s);
`else
    crc_field_s = 16'hBEEF;
`endif
  end

  // Refresh interval timer; held at its reload value while the link is down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r <= TIMER_INIT;
    end else if (!active_s || (timer_r == {TW{1'b0}})) begin
      timer_r <= TIMER_INIT;
    end else begin
      timer_r <= timer_r - {{(TW-1){1'b0}}, 1'b1};
    end
  end

  // Per-channel pending/seeded state and credit holding registers. A fresh
  // request beats both the grant clear and the refresh on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r   <= {NUM_CH{1'b0}};
      seeded_r    <= {NUM_CH{1'b0}};
      pend_hdr_r  <= {(NUM_CH*8){1'b0}};
      pend_data_r <= {(NUM_CH*12){1'b0}};
      last_hdr_r  <= {(NUM_CH*8){1'b0}};
      last_data_r <= {(NUM_CH*12){1'b0}};
    end else if (!active_s) begin
      pending_r <= {NUM_CH{1'b0}};
      seeded_r  <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (update_req_i[i]) begin
          pending_r[i]   <= 1'b1;
          pend_hdr_r[i]  <= hdr_credit_i[8*i +: 8];
          pend_data_r[i] <= data_credit_i[12*i +: 12];
        end else if (load_s && (grant_idx_s == PW'(i))) begin
          pending_r[i] <= 1'b0;
        end else if (refresh_s && seeded_r[i] && !pending_r[i]) begin
          pending_r[i]   <= 1'b1;
          pend_hdr_r[i]  <= last_hdr_r[i];
          pend_data_r[i] <= last_data_r[i];
        end else begin
          pending_r[i] <= pending_r[i];
        end
        if (load_s && (grant_idx_s == PW'(i))) begin
          last_hdr_r[i]  <= pend_hdr_r[i];
          last_data_r[i] <= pend_data_r[i];
          seeded_r[i]    <= 1'b1;
        end else begin
          seeded_r[i] <= seeded_r[i];
        end
      end
    end
  end

  // Round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= {PW{1'b0}};
    end else if (!active_s) begin
      rr_ptr_r <= {PW{1'b0}};
    end else if (load_s) begin
      rr_ptr_r <= next_ptr_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Output register; a link drop withdraws the DLLP without waiting for ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dllp_r  <= 48'd0;
      valid_r <= 1'b0;
    end else if (!active_s) begin
      valid_r <= 1'b0;
    end else if (load_s) begin
      dllp_r  <= {crc_field_s, body_s};
      valid_r <= 1'b1;
    end else if (dll_dllp_ready_i) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign dll_dllp_o       = dllp_r;
  assign dll_dllp_valid_o = valid_r;

endmodule
